dmem_port: RTL and testbench
============================

# dmem_port

Memory-side endpoint for the store buffer and the load unit. It accepts retired stores on the store buffer's retire interface (`stretire`/`retaddr`/`retdata`) into a small write queue. It serves load requests by forwarding from the store buffer or the write queue, or by reading data memory. It drives `memoccupy_ld` back to the store buffer and owns the single request/acknowledge port to data memory.

## Interface
- `WQ_DEPTH`, default 2, write-queue entries (power of 2, ≥2)
- `WQ_SEL`, default 1, log2(`WQ_DEPTH`)

Ports:
- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-low
- `prmiss` in 1: branch mispredict; kills the pending load
- `st_we` in 1: retired store valid (from `stretire`)
- `st_addr` in `ADDR_LEN`: retired store address
- `st_data` in `DATA_LEN`: retired store data
- `memoccupy_ld` out 1: registered; store buffer must not retire while high
- `ld_req` in 1: load request
- `ld_addr` in `ADDR_LEN`: load address
- `ld_rdy` out 1: load can be accepted this cycle
- `ld_done` out 1: one-cycle pulse, load result valid
- `ld_data` out `DATA_LEN`: load result, valid with `ld_done`
- `sb_ldaddr` out `ADDR_LEN`: combinationally equal to `ld_addr`
- `sb_hit` in 1: store-buffer forward hit
- `sb_lddata` in `DATA_LEN`: store-buffer forward data
- `mem_req` out 1: memory request, held until `mem_ack`
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out `ADDR_LEN`: memory address
- `mem_wdata` out `DATA_LEN`: write data
- `mem_ack` in 1: one-cycle completion pulse
- `mem_rdata` in `DATA_LEN`: read data, valid with `mem_ack`

## Operation
- **Write queue (WQ)**
  - FIFO of {addr, data}.
  - Push on `st_we`. Pop on `mem_ack` of a write.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo `WQ_DEPTH`.
- **`memoccupy_ld`**
  - Registered. Next value = (load FSM next state ≠ L_IDLE) | (WQ count_next == `WQ_DEPTH`).
  - `st_we` while `memoccupy_ld`=1 is a protocol violation; the push is dropped.
- **Memory port**
  - One outstanding transaction at a time.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable while `mem_req`=1.
  - Write issue: WQ non-empty, port idle, load FSM not in L_RD. The head entry is sent.
- **Load FSM**
  - States: L_IDLE, L_DRAIN, L_RD, L_RESP.
  - `ld_rdy` = (state == L_IDLE).
  - From L_IDLE, on `ld_req`: capture `ld_addr` and clear the kill flag. Forward source priority:
    - `sb_hit` → capture `sb_lddata`, go to L_RESP.
    - Else youngest WQ entry with a matching address → capture its data, go to L_RESP.
    - Else → L_DRAIN.
  - L_DRAIN: when WQ is empty and the port is idle, issue the read and go to L_RD.
  - L_RD: on `mem_ack`, capture `mem_rdata` and go to L_RESP.
  - L_RESP: pulse `ld_done` unless killed, then go to L_IDLE.
- **`prmiss`**
  - Sets the kill flag for the pending load.
  - In L_DRAIN, the FSM goes straight to L_IDLE.
  - In L_RD, the FSM waits for `mem_ack`, discards the data, and goes to L_IDLE without `ld_done`.
  - `prmiss` in the same cycle as `ld_req` acceptance: the load is killed.
  - WQ contents are unaffected.
- **Reset**
  - Asynchronous and active-low; can occur mid-transaction.
  - Clears the WQ, the FSM (L_IDLE) and all outputs: `memoccupy_ld`, `ld_done`, `ld_data`, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` = 0; `ld_rdy` = 1.

## Timing
- Store with an idle port: `st_we` at cycle N → `mem_req`/`mem_we` = 1 at N+1.
  - Ack at cycle A → the next queued write's `mem_req` at A+1.
- Forwarded load: accepted at N → `ld_done` at N+1. No memory access.
- Memory load with an empty WQ and idle port: accepted at N → L_DRAIN at N+1 → read `mem_req` at N+2.
  - Ack at cycle M → `ld_done` at M+1.
- `memoccupy_ld` rises the cycle after load acceptance. It falls the cycle after L_RESP, or after the killed return to L_IDLE.

## Structure
- `DATA_LEN` and `ADDR_LEN` come from the shared constants header. Load FSM state encodings go there too.
- One sub-module: `dmem_wq`, the write-queue FIFO with a youngest-match address CAM. It reports hit and data to the parent.

## Test plan
- **Reset:** assert `reset`=0 mid-write with `mem_req`=1 → `mem_req`=0 and `ld_rdy`=1 immediately; WQ empty after release.
- **Store drain:** `st_we` with 0x1000/0xDEADBEEF, ack 3 cycles later → `mem_req`=1 with `mem_we`=1 and 0x1000/0xDEADBEEF one cycle after `st_we`; WQ empty after the ack.
- **Store-buffer forward:** `ld_addr`=0x2000, `sb_hit`=1, `sb_lddata`=0x11 → `ld_done` next cycle with 0x11; `mem_req` stays 0.
- **WQ forward:** hold `mem_ack` low; push 0x3000/0xA then 0x3000/0xB → `memoccupy_ld`=1 once 2 entries are queued. Then load 0x3000 with `sb_hit`=0 → `ld_done` with 0xB.
- **Load behind write:** WQ holds 0x4000/0x5; load 0x5000 → read `mem_req` only after the write ack; `mem_rdata`=0x77 → `ld_done` with 0x77 one cycle after the read ack.
- **Kill:** `prmiss` during L_RD → no `ld_done`; `ld_rdy`=1 the cycle after `mem_ack`; a following load completes normally.

Source files
------------

// File: rtl/dmem_port_pkg.sv
// Shared constants for the data-memory port: bus widths and load FSM encodings.
package dmem_port_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_DRAIN = 2'd1,
        L_RD    = 2'd2,
        L_RESP  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/dmem_port_wq.sv
// Write queue for retired stores: FIFO of {addr, data} with a youngest-match
// address lookup and a look-ahead view of the entry that will be head next cycle.
module dmem_wq
    import dmem_port_pkg::*;
#(
    parameter int WQ_DEPTH = 2,
    parameter int WQ_SEL   = 1
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [ADDR_LEN-1:0] push_addr_i,
    input  logic [DATA_LEN-1:0] push_data_i,
    input  logic                pop_i,
    input  logic [ADDR_LEN-1:0] lookup_addr_i,
    output logic                hit_o,
    output logic [DATA_LEN-1:0] hit_data_o,
    output logic [WQ_SEL:0]     count_o,
    output logic [WQ_SEL:0]     count_next_o,
    output logic                head_valid_o,
    output logic [ADDR_LEN-1:0] head_addr_o,
    output logic [DATA_LEN-1:0] head_data_o
);

    localparam logic [WQ_SEL:0] FULL_CNT = (WQ_SEL + 1)'(WQ_DEPTH);

    logic [ADDR_LEN-1:0] addr_mem [WQ_DEPTH];
    logic [DATA_LEN-1:0] data_mem [WQ_DEPTH];

    logic [WQ_SEL-1:0] wr_ptr_q, wr_ptr_d;
    logic [WQ_SEL-1:0] rd_ptr_q, rd_ptr_d;
    logic [WQ_SEL:0]   count_q, count_d;
    logic [WQ_SEL:0]   remain;
    logic              push_ok, pop_ok;

    logic [WQ_SEL-1:0]   age_idx [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] match_age;

    assign push_ok = push_i & ((count_q != FULL_CNT) | pop_i);
    assign pop_ok  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + WQ_SEL'(push_ok);
        rd_ptr_d = rd_ptr_q + WQ_SEL'(pop_ok);
        remain   = count_q - (WQ_SEL + 1)'(pop_ok);
        count_d  = remain + (WQ_SEL + 1)'(push_ok);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // age_idx[k] is the k-th oldest slot; match_age is indexed by age, not slot
    for (genvar gi = 0; gi < WQ_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_q == WQ_SEL'(gi))) begin
                addr_mem[gi] <= push_addr_i;
                data_mem[gi] <= push_data_i;
            end
        end

        assign age_idx[gi]   = rd_ptr_q + WQ_SEL'(gi);
        assign match_age[gi] = ((WQ_SEL + 1)'(gi) < count_q) &&
                               (addr_mem[age_idx[gi]] == lookup_addr_i);
    end

    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < WQ_DEPTH; k++) begin
            if (match_age[k]) begin
                hit_o      = 1'b1;
                hit_data_o = data_mem[age_idx[k]];
            end
        end
    end

    // When the queue drains to nothing this cycle, an incoming store becomes
    // the head directly so it can be issued without a bubble.
    always_comb begin
        head_valid_o = (count_d != '0);
        if (remain == '0) begin
            head_addr_o = push_addr_i;
            head_data_o = push_data_i;
        end else begin
            head_addr_o = addr_mem[rd_ptr_d];
            head_data_o = data_mem[rd_ptr_d];
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/dmem_port.sv
// Memory-side endpoint: queues retired stores, serves loads by forwarding or by
// reading data memory, and owns the single req/ack port to data memory.
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int WQ_DEPTH = 2,
    parameter int WQ_SEL   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prmiss,
    input  logic                st_we,
    input  logic [ADDR_LEN-1:0] st_addr,
    input  logic [DATA_LEN-1:0] st_data,
    output logic                memoccupy_ld,
    input  logic                ld_req,
    input  logic [ADDR_LEN-1:0] ld_addr,
    output logic                ld_rdy,
    output logic                ld_done,
    output logic [DATA_LEN-1:0] ld_data,
    output logic [ADDR_LEN-1:0] sb_ldaddr,
    input  logic                sb_hit,
    input  logic [DATA_LEN-1:0] sb_lddata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam logic [WQ_SEL:0] FULL_CNT = (WQ_SEL + 1)'(WQ_DEPTH);

    ld_state_e           state_q, state_d;
    logic                kill_q, kill_d;
    logic [ADDR_LEN-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_LEN-1:0] ld_data_q, ld_data_d;
    logic                ld_done_q, ld_done_d;
    logic                ld_rdy_q, ld_rdy_d;
    logic                memoccupy_q, memoccupy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;

    logic                wq_push, wq_pop, wq_hit, wq_head_valid;
    logic [DATA_LEN-1:0] wq_hit_data, wq_head_data;
    logic [ADDR_LEN-1:0] wq_head_addr;
    logic [WQ_SEL:0]     wq_count, wq_count_next;
    logic                port_done, port_free, rd_ack, rd_issue;

    assign port_done = mem_req_q & mem_ack;
    assign port_free = ~mem_req_q | port_done;
    assign rd_ack    = port_done & ~mem_we_q;
    assign wq_pop    = port_done & mem_we_q;
    // A store arriving while memoccupy_ld is high is a protocol violation and is dropped
    assign wq_push   = st_we & ~memoccupy_q;

    dmem_wq #(
        .WQ_DEPTH(WQ_DEPTH),
        .WQ_SEL  (WQ_SEL)
    ) u_wq (
        .clk          (clk),
        .rst_ni       (reset),
        .push_i       (wq_push),
        .push_addr_i  (st_addr),
        .push_data_i  (st_data),
        .pop_i        (wq_pop),
        .lookup_addr_i(ld_addr),
        .hit_o        (wq_hit),
        .hit_data_o   (wq_hit_data),
        .count_o      (wq_count),
        .count_next_o (wq_count_next),
        .head_valid_o (wq_head_valid),
        .head_addr_o  (wq_head_addr),
        .head_data_o  (wq_head_data)
    );

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q | prmiss;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        rd_issue  = 1'b0;

        unique case (state_q)
            L_IDLE: begin
                kill_d = kill_q;
                if (ld_req) begin
                    ld_addr_d = ld_addr;
                    kill_d    = prmiss;
                    if (sb_hit) begin
                        ld_data_d = sb_lddata;
                        state_d   = L_RESP;
                    end else if (wq_hit) begin
                        ld_data_d = wq_hit_data;
                        state_d   = L_RESP;
                    end else begin
                        state_d   = L_DRAIN;
                    end
                end
            end
            L_DRAIN: begin
                if (kill_d) begin
                    state_d = L_IDLE;
                end else if ((wq_count == '0) && !mem_req_q) begin
                    rd_issue = 1'b1;
                    state_d  = L_RD;
                end
            end
            L_RD: begin
                if (rd_ack) begin
                    if (kill_d) begin
                        state_d = L_IDLE;
                    end else begin
                        ld_data_d = mem_rdata;
                        state_d   = L_RESP;
                    end
                end
            end
            L_RESP: begin
                state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase

        ld_done_d   = (state_d == L_RESP) && !kill_d;
        ld_rdy_d    = (state_d == L_IDLE);
        memoccupy_d = (state_d != L_IDLE) || (wq_count_next == FULL_CNT);
    end

    // Reads win over writes; a pending load never overtakes queued stores
    // because L_DRAIN only issues once the queue is empty.
    always_comb begin
        mem_req_d   = mem_req_q & ~port_done;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_issue) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = ld_addr_q;
        end else if (port_free && wq_head_valid && (state_q != L_RD)) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wq_head_addr;
            mem_wdata_d = wq_head_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= L_IDLE;
            kill_q      <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            ld_done_q   <= 1'b0;
            ld_rdy_q    <= 1'b1;
            memoccupy_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            ld_done_q   <= ld_done_d;
            ld_rdy_q    <= ld_rdy_d;
            memoccupy_q <= memoccupy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign memoccupy_ld = memoccupy_q;
    assign ld_rdy       = ld_rdy_q;
    assign ld_done      = ld_done_q;
    assign ld_data      = ld_data_q;
    assign sb_ldaddr    = ld_addr;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: reset, store drain, forwarding, load behind write, kill.
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        prmiss;
    logic        st_we;
    logic [31:0] st_addr, st_data;
    logic        memoccupy_ld;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_rdy, ld_done;
    logic [31:0] ld_data, sb_ldaddr;
    logic        sb_hit;
    logic [31:0] sb_lddata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    dmem_port dut (
        .clk         (clk),
        .reset       (reset),
        .prmiss      (prmiss),
        .st_we       (st_we),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .memoccupy_ld(memoccupy_ld),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_rdy      (ld_rdy),
        .ld_done     (ld_done),
        .ld_data     (ld_data),
        .sb_ldaddr   (sb_ldaddr),
        .sb_hit      (sb_hit),
        .sb_lddata   (sb_lddata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) begin
            $display("check %-22s observed %h expected %h ok", tag, got, exp);
        end else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0; prmiss = 1'b0; st_we = 1'b0; st_addr = '0; st_data = '0;
        ld_req = 1'b0; ld_addr = '0; sb_hit = 1'b0; sb_lddata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        chk("rst_memoccupy", {31'd0, memoccupy_ld}, 32'd0);
        chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        step();

        // store drain
        st_we = 1'b1; st_addr = 32'h1000; st_data = 32'hDEADBEEF;
        step(); st_we = 1'b0;
        chk("st_mem_req", {31'd0, mem_req}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h1000);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_memoccupy", {31'd0, memoccupy_ld}, 32'd0);
        step(); step();
        chk("st_req_held", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("st_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        chk("st_no_reissue", {31'd0, mem_req}, 32'd0);

        // store-buffer forward
        ld_addr = 32'h2000; sb_hit = 1'b1; sb_lddata = 32'h11; ld_req = 1'b1;
        #1;
        chk("sb_ldaddr", sb_ldaddr, 32'h2000);
        chk("sbf_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        step(); ld_req = 1'b0; sb_hit = 1'b0;
        chk("sbf_ld_done", {31'd0, ld_done}, 32'd1);
        chk("sbf_ld_data", ld_data, 32'h11);
        chk("sbf_mem_req", {31'd0, mem_req}, 32'd0);
        chk("sbf_ld_rdy_low", {31'd0, ld_rdy}, 32'd0);
        chk("sbf_memoccupy", {31'd0, memoccupy_ld}, 32'd1);
        step();
        chk("sbf_done_clear", {31'd0, ld_done}, 32'd0);
        chk("sbf_ld_rdy_back", {31'd0, ld_rdy}, 32'd1);
        chk("sbf_memocc_fall", {31'd0, memoccupy_ld}, 32'd0);

        // write-queue forward, youngest entry wins
        st_we = 1'b1; st_addr = 32'h3000; st_data = 32'hA;
        step();
        chk("wqf_req_a", {31'd0, mem_req}, 32'd1);
        chk("wqf_memocc_1", {31'd0, memoccupy_ld}, 32'd0);
        st_data = 32'hB;
        step(); st_we = 1'b0;
        chk("wqf_memocc_full", {31'd0, memoccupy_ld}, 32'd1);
        chk("wqf_wdata_a", mem_wdata, 32'hA);
        ld_addr = 32'h3000; ld_req = 1'b1;
        step(); ld_req = 1'b0;
        chk("wqf_ld_done", {31'd0, ld_done}, 32'd1);
        chk("wqf_ld_data", ld_data, 32'hB);
        chk("wqf_wdata_stable", mem_wdata, 32'hA);
        step();
        chk("wqf_memocc_still", {31'd0, memoccupy_ld}, 32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("wqf_b2b_req", {31'd0, mem_req}, 32'd1);
        chk("wqf_b2b_wdata", mem_wdata, 32'hB);
        chk("wqf_memocc_fall", {31'd0, memoccupy_ld}, 32'd0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("wqf_drained", {31'd0, mem_req}, 32'd0);

        // load behind a queued write
        st_we = 1'b1; st_addr = 32'h4000; st_data = 32'h5;
        step(); st_we = 1'b0;
        chk("lbw_write_we", {31'd0, mem_we}, 32'd1);
        ld_addr = 32'h5000; ld_req = 1'b1;
        step(); ld_req = 1'b0;
        chk("lbw_memocc", {31'd0, memoccupy_ld}, 32'd1);
        chk("lbw_no_done", {31'd0, ld_done}, 32'd0);
        step(); step();
        chk("lbw_still_write", mem_addr, 32'h4000);
        chk("lbw_still_we", {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("lbw_gap", {31'd0, mem_req}, 32'd0);
        step();
        chk("lbw_rd_req", {31'd0, mem_req}, 32'd1);
        chk("lbw_rd_we", {31'd0, mem_we}, 32'd0);
        chk("lbw_rd_addr", mem_addr, 32'h5000);
        mem_ack = 1'b1; mem_rdata = 32'h77; step(); mem_ack = 1'b0;
        chk("lbw_ld_done", {31'd0, ld_done}, 32'd1);
        chk("lbw_ld_data", ld_data, 32'h77);
        chk("lbw_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        chk("lbw_done_clear", {31'd0, ld_done}, 32'd0);
        chk("lbw_memocc_fall", {31'd0, memoccupy_ld}, 32'd0);

        // prmiss in the acceptance cycle kills a forwarded load
        ld_addr = 32'h2100; sb_hit = 1'b1; sb_lddata = 32'h33; ld_req = 1'b1; prmiss = 1'b1;
        step(); ld_req = 1'b0; sb_hit = 1'b0; prmiss = 1'b0;
        chk("kacc_no_done", {31'd0, ld_done}, 32'd0);
        chk("kacc_memocc", {31'd0, memoccupy_ld}, 32'd1);
        step();
        chk("kacc_ld_rdy", {31'd0, ld_rdy}, 32'd1);

        // prmiss while the read is outstanding
        ld_addr = 32'h6000; ld_req = 1'b1;
        step(); ld_req = 1'b0;
        step();
        chk("krd_req", {31'd0, mem_req}, 32'd1);
        chk("krd_addr", mem_addr, 32'h6000);
        prmiss = 1'b1; step(); prmiss = 1'b0;
        chk("krd_wait_rdy", {31'd0, ld_rdy}, 32'd0);
        chk("krd_req_held", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h99; step(); mem_ack = 1'b0;
        chk("krd_no_done", {31'd0, ld_done}, 32'd0);
        chk("krd_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        step();
        chk("krd_no_done2", {31'd0, ld_done}, 32'd0);
        chk("krd_memocc", {31'd0, memoccupy_ld}, 32'd0);
        ld_addr = 32'h7000; ld_req = 1'b1;
        step(); ld_req = 1'b0;
        step();
        chk("post_kill_addr", mem_addr, 32'h7000);
        mem_ack = 1'b1; mem_rdata = 32'h1234; step(); mem_ack = 1'b0;
        chk("post_kill_done", {31'd0, ld_done}, 32'd1);
        chk("post_kill_data", ld_data, 32'h1234);
        step();

        // asynchronous reset in the middle of a write
        st_we = 1'b1; st_addr = 32'h8000; st_data = 32'hCAFE;
        step(); st_we = 1'b0;
        chk("rmid_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rmid_req_async", {31'd0, mem_req}, 32'd0);
        chk("rmid_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        chk("rmid_mem_addr", mem_addr, 32'd0);
        chk("rmid_mem_wdata", mem_wdata, 32'd0);
        step(); reset = 1'b1;
        step();
        chk("rmid_no_reissue", {31'd0, mem_req}, 32'd0);
        ld_addr = 32'h8000; ld_req = 1'b1;
        step(); ld_req = 1'b0;
        chk("rmid_no_wq_fwd", {31'd0, ld_done}, 32'd0);
        step();
        chk("rmid_rd_req", {31'd0, mem_req}, 32'd1);
        chk("rmid_rd_we", {31'd0, mem_we}, 32'd0);
        chk("rmid_rd_addr", mem_addr, 32'h8000);
        mem_ack = 1'b1; mem_rdata = 32'h5A; step(); mem_ack = 1'b0;
        chk("rmid_ld_data", ld_data, 32'h5A);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
